// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the RV32IM pipeline.
// Runs loads and stores over a req/ready data bus. While a transfer is in
// flight it stalls the upstream stages. It drives registered MEM/WB outputs
// and reports misaligned, illegal and bus-timeout faults.
//
// Bus handshake: dmem_req_o is registered. Once raised, req/we/addr/wdata/be
// hold steady until the slave answers. A transfer completes on the rising
// edge where dmem_req_o && dmem_ready_i; dmem_rdata_i is sampled on that same
// edge. dmem_ready_i is ignored while dmem_req_o is low.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_write_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] mem_wb_result_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_write_o,
    output logic        valid_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [31:0] fault_addr_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    // Last no-ready cycle that is still allowed before timing out.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        is_load_q;
    logic        reg_write_q;
    logic        timed_out_q;

    logic        is_mem;
    logic        is_illegal;
    logic        is_misaligned;
    logic        mem_ok;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign dbg_state_o = state;

    // Decode the instruction in EX/MEM: is it a memory op, and is it legal and aligned?
    always_comb begin
        is_mem        = valid_i && (mem_read_i || mem_write_i);
        is_illegal    = 1'b0;
        is_misaligned = 1'b0;
        if (mem_read_i && mem_write_i) begin
            is_illegal = 1'b1;
        end
        if (funct3_i == 3'd3 || funct3_i == 3'd6 || funct3_i == 3'd7) begin
            is_illegal = 1'b1;
        end
        // Stores have no unsigned variants.
        if (mem_write_i && (funct3_i == 3'd4 || funct3_i == 3'd5)) begin
            is_illegal = 1'b1;
        end
        if (funct3_i[1:0] == 2'b01 && alu_result_i[0]) begin
            is_misaligned = 1'b1;
        end
        if (funct3_i[1:0] == 2'b10 && alu_result_i[1:0] != 2'b00) begin
            is_misaligned = 1'b1;
        end
        mem_ok = is_mem && !is_illegal && !is_misaligned;
    end

    // Build lane-replicated write data and byte enables from the access size and offset.
    always_comb begin
        acc_be    = 4'b1111;
        acc_wdata = rs2_data_i;
        unique case (funct3_i[1:0])
            2'b00: begin
                acc_be    = 4'b0001 << alu_result_i[1:0];
                acc_wdata = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                acc_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{rs2_data_i[15:0]}};
            end
            default: begin
                acc_be    = 4'b1111;
                acc_wdata = rs2_data_i;
            end
        endcase
    end

    // Select the addressed byte/half of the captured read word, then sign- or zero-extend it.
    always_comb begin
        ld_byte = rdata_q[7:0];
        unique case (addr_q[1:0])
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            2'd3: ld_byte = rdata_q[31:24];
        endcase
        ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        unique case (funct3_q)
            3'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    load_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    load_data = {24'd0, ld_byte};
            3'd5:    load_data = {16'd0, ld_half};
            default: load_data = rdata_q;
        endcase
    end

    // Freeze upstream while a legal access is being accepted or is in flight.
    always_comb begin
        stall_o = (state == S_ACCESS) || (state == S_IDLE && mem_ok);
    end

    // Access FSM, bus request registers and MEM/WB output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            wait_cnt        <= 8'd0;
            addr_q          <= 32'd0;
            rdata_q         <= 32'd0;
            funct3_q        <= 3'd0;
            rd_q            <= 5'd0;
            is_load_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            timed_out_q     <= 1'b0;
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_addr_o     <= 32'd0;
            dmem_wdata_o    <= 32'd0;
            dmem_be_o       <= 4'd0;
            mem_wb_result_o <= 32'd0;
            rd_addr_o       <= 5'd0;
            reg_write_o     <= 1'b0;
            valid_o         <= 1'b0;
            fault_o         <= 1'b0;
            fault_cause_o   <= 2'd0;
            fault_addr_o    <= 32'd0;
        end else begin
            // fault_o is a pulse; MEM/WB sees a bubble unless a branch below loads it.
            fault_o <= 1'b0;
            valid_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mem_ok) begin
                        state        <= S_ACCESS;
                        wait_cnt     <= 8'd0;
                        timed_out_q  <= 1'b0;
                        addr_q       <= alu_result_i;
                        funct3_q     <= funct3_i;
                        rd_q         <= rd_addr_i;
                        is_load_q    <= mem_read_i;
                        reg_write_q  <= reg_write_i;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_write_i;
                        dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
                        dmem_wdata_o <= acc_wdata;
                        dmem_be_o    <= acc_be;
                        reg_write_o  <= 1'b0;
                    end else begin
                        valid_o         <= valid_i;
                        rd_addr_o       <= rd_addr_i;
                        mem_wb_result_o <= alu_result_i;
                        if (is_mem) begin
                            reg_write_o   <= 1'b0;
                            fault_o       <= 1'b1;
                            fault_cause_o <= is_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
                            fault_addr_o  <= alu_result_i;
                        end else begin
                            reg_write_o <= valid_i && reg_write_i;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready_i) begin
                        dmem_req_o <= 1'b0;
                        rdata_q    <= dmem_rdata_i;
                        state      <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        dmem_req_o    <= 1'b0;
                        timed_out_q   <= 1'b1;
                        fault_o       <= 1'b1;
                        fault_cause_o <= CAUSE_TIMEOUT;
                        fault_addr_o  <= addr_q;
                        state         <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    valid_o         <= 1'b1;
                    rd_addr_o       <= rd_q;
                    reg_write_o     <= is_load_q && reg_write_q && !timed_out_q;
                    mem_wb_result_o <= is_load_q ? load_data : addr_q;
                    state           <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table-driven bench for mem_stage (MAX_WAIT = 4).
module tb_mem_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_data_i;
    logic [2:0]  funct3_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [4:0]  rd_addr_i;
    logic        reg_write_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] mem_wb_result_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o;
    logic        valid_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic [31:0] fault_addr_o;
    logic [1:0]  dbg_state_o;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_result_i(alu_result_i),
        .rs2_data_i(rs2_data_i), .funct3_i(funct3_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_wb_result_o(mem_wb_result_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
        .valid_o(valid_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
        .fault_addr_o(fault_addr_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  last_cause = 2'd0;
    logic [31:0] last_faddr = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_result(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got 0x%08h expected <empty queue>", name, mem_wb_result_o);
        end else begin
            e = exp_q.pop_front();
            check(name, mem_wb_result_o, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_i      = 1'b0;
        alu_result_i = 32'd0;
        rs2_data_i   = 32'd0;
        funct3_i     = 3'd0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        rd_addr_i    = 5'd0;
        reg_write_i  = 1'b0;
    endtask

    task automatic drive_op(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [2:0] f3, input logic mr, input logic mw,
                            input logic [4:0] rd, input logic we);
        valid_i      = v;
        alu_result_i = alu;
        rs2_data_i   = rs2;
        funct3_i     = f3;
        mem_read_i   = mr;
        mem_write_i  = mw;
        rd_addr_i    = rd;
        reg_write_i  = we;
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic [4:0]  rd;
        logic        we;
        logic        e_valid;
        logic        e_we;
        logic        e_fault;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        logic got_stall;
        vecs[0]  = '{1'b1, 32'h0000_1234, 3'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 2'b00}; // ALU pass-through
        vecs[1]  = '{1'b1, 32'h0000_0301, 3'd2, 1'b1, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 2'b01}; // LW misaligned
        vecs[2]  = '{1'b0, 32'h0000_AAAA, 3'd0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // bubble
        vecs[3]  = '{1'b1, 32'h0000_0405, 3'd1, 1'b1, 1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b1, 2'b01}; // LH odd addr
        vecs[4]  = '{1'b1, 32'h0000_0055, 3'd0, 1'b0, 1'b0, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00}; // no reg write
        vecs[5]  = '{1'b1, 32'h0000_0502, 3'd2, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 2'b01}; // SW misaligned
        vecs[6]  = '{1'b1, 32'h0000_0600, 3'd3, 1'b1, 1'b0, 5'd4,  1'b1, 1'b1, 1'b0, 1'b1, 2'b10}; // funct3 3
        vecs[7]  = '{1'b1, 32'hCAFE_0000, 3'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00}; // pass, cause holds
        vecs[8]  = '{1'b1, 32'h0000_0700, 3'd4, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 2'b10}; // store funct3 4
        vecs[9]  = '{1'b1, 32'h0000_0800, 3'd2, 1'b1, 1'b1, 5'd6,  1'b1, 1'b1, 1'b0, 1'b1, 2'b10}; // read+write
        vecs[10] = '{1'b0, 32'h0000_0904, 3'd3, 1'b1, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00}; // invalid mem op
        vecs[11] = '{1'b1, 32'h0000_0A04, 3'd6, 1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 2'b10}; // funct3 6

        rst_n        = 1'b0;
        dmem_ready_i = 1'b0;
        dmem_rdata_i = 32'd0;
        drive_idle();
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        check("rst_state", 32'(dbg_state_o), 32'd0);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_result", mem_wb_result_o, 32'd0);

        // table of single-cycle cases
        for (int i = 0; i < 12; i++) begin
            drive_op(vecs[i].v, vecs[i].alu, 32'h1111_2222, vecs[i].f3, vecs[i].mr, vecs[i].mw,
                     vecs[i].rd, vecs[i].we);
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall_o), 32'd0);
            if (!vecs[i].e_fault) exp_q.push_back(vecs[i].alu);
            if (vecs[i].e_fault) begin
                last_cause = vecs[i].e_cause;
                last_faddr = vecs[i].alu;
            end
            tick();
            check($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_we", i), 32'(reg_write_o), 32'(vecs[i].e_we));
            check($sformatf("v%0d_rd", i), 32'(rd_addr_o), 32'(vecs[i].rd));
            check($sformatf("v%0d_fault", i), 32'(fault_o), 32'(vecs[i].e_fault));
            check($sformatf("v%0d_cause", i), 32'(fault_cause_o), 32'(last_cause));
            check($sformatf("v%0d_faddr", i), fault_addr_o, last_faddr);
            check($sformatf("v%0d_req", i), 32'(dmem_req_o), 32'd0);
            if (!vecs[i].e_fault) check_result($sformatf("v%0d_result", i));
        end

        // LB 0x103, ready on first req cycle
        drive_op(1'b1, 32'h0000_0103, 32'd0, 3'd0, 1'b1, 1'b0, 5'd10, 1'b1);
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h80AA_BBCC;
        exp_q.push_back(32'hFFFF_FF80);
        #1;
        check("lb_stall_idle", 32'(stall_o), 32'd1);
        tick();
        check("lb_req", 32'(dmem_req_o), 32'd1);
        check("lb_we", 32'(dmem_we_o), 32'd0);
        check("lb_addr", dmem_addr_o, 32'h0000_0100);
        check("lb_stall_access", 32'(stall_o), 32'd1);
        check("lb_valid_access", 32'(valid_o), 32'd0);
        tick();
        check("lb_req_done", 32'(dmem_req_o), 32'd0);
        check("lb_stall_done", 32'(stall_o), 32'd0);
        tick();
        drive_idle();
        dmem_ready_i = 1'b0;
        check_result("lb_result");
        check("lb_valid", 32'(valid_o), 32'd1);
        check("lb_rf_we", 32'(reg_write_o), 32'd1);
        check("lb_rd", 32'(rd_addr_o), 32'd10);
        check("lb_state", 32'(dbg_state_o), 32'd0);

        // SH 0x202, ready after 3 wait cycles (last allowed cycle with MAX_WAIT = 4)
        drive_op(1'b1, 32'h0000_0202, 32'hDEAD_5678, 3'd1, 1'b0, 1'b1, 5'd0, 1'b0);
        exp_q.push_back(32'h0000_0202);
        tick();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready_i = 1'b1;
            if (dmem_req_o && dmem_we_o && dmem_be_o == 4'b1100 && dmem_wdata_o == 32'h5678_5678 &&
                dmem_addr_o == 32'h0000_0200 && stall_o) n++;
            tick();
        end
        dmem_ready_i = 1'b0;
        check("sh_req_stable_cycles", 32'(n), 32'd4);
        check("sh_req_dropped", 32'(dmem_req_o), 32'd0);
        check("sh_no_fault", 32'(fault_o), 32'd0);
        tick();
        drive_idle();
        check("sh_valid", 32'(valid_o), 32'd1);
        check("sh_rf_we", 32'(reg_write_o), 32'd0);
        check_result("sh_result");

        // Timeout: LW 0x400, ready never comes
        drive_op(1'b1, 32'h0000_0400, 32'd0, 3'd2, 1'b1, 1'b0, 5'd4, 1'b1);
        tick();
        n = 0;
        while (dmem_req_o && n < 10) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd4);
        check("to_fault", 32'(fault_o), 32'd1);
        check("to_cause", 32'(fault_cause_o), 32'd3);
        check("to_faddr", fault_addr_o, 32'h0000_0400);
        got_stall = stall_o;
        check("to_stall_done", 32'(got_stall), 32'd0);
        tick();
        drive_idle();
        check("to_fault_pulse", 32'(fault_o), 32'd0);
        check("to_valid", 32'(valid_o), 32'd1);
        check("to_rf_we", 32'(reg_write_o), 32'd0);
        check("to_cause_hold", 32'(fault_cause_o), 32'd3);

        // Reset mid-ACCESS
        drive_op(1'b1, 32'h0000_0500, 32'd0, 3'd2, 1'b1, 1'b0, 5'd12, 1'b1);
        tick();
        tick();
        check("rm_req_before", 32'(dmem_req_o), 32'd1);
        rst_n = 1'b0;
        drive_idle();
        tick();
        check("rm_req", 32'(dmem_req_o), 32'd0);
        check("rm_state", 32'(dbg_state_o), 32'd0);
        check("rm_fault", 32'(fault_o), 32'd0);
        check("rm_cause", 32'(fault_cause_o), 32'd0);
        check("rm_faddr", fault_addr_o, 32'd0);
        check("rm_valid", 32'(valid_o), 32'd0);
        check("rm_result", mem_wb_result_o, 32'd0);
        check("rm_addr", dmem_addr_o, 32'd0);
        check("rm_stall", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rm_fault_after", 32'(fault_o), 32'd0);
        check("rm_req_after", 32'(dmem_req_o), 32'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
